// File: rtl/tdm_pkg.sv
// ----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM receive path: channel count, slot index
// width and the slot index type used by the slot counter and the demux top.
// No ports; imported by tdm_slot_ctr and tdm_demux1_4.
// ----------------------------------------------------------------------------
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  // Index of the final slot in a frame; accepting a beat here completes it.
  localparam slot_t LAST_SLOT = slot_t'(NUM_CH - 1);

endpackage

// File: rtl/tdm_slot_ctr.sv
// ----------------------------------------------------------------------------
// tdm_slot_ctr
// Modulo-4 slot counter for the TDM demux. Tracks which slot the next
// accepted beat belongs to. A sync beat is always slot 0, so after it the
// counter lands on 1 regardless of where it was.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous reset, active-high (slot returns to 0)
//   adv   in   a beat is accepted this cycle
//   sync  in   the accepted beat is a frame start (only meaningful with adv)
//   slot  out  slot the next accepted beat will fill
//   wrap  out  combinational: this cycle's beat fills the last slot
// ----------------------------------------------------------------------------
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  adv,
  input  logic  sync,
  output slot_t slot,
  output logic  wrap
);

  slot_t slot_q;
  slot_t slot_d;
  logic  syncBeat;

  assign syncBeat = adv && sync;

  // Next slot: a sync beat occupies slot 0, so the following beat is slot 1.
  // Plain beats advance by one and the 2-bit type wraps 3 -> 0 naturally.
  always_comb begin
    slot_d = slot_q;
    if (syncBeat) begin
      slot_d = slot_t'(1);
    end else if (adv) begin
      slot_d = slot_q + slot_t'(1);
    end
  end

  // Slot register; reset drops any partially received frame position.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // A sync on the last slot is a resync, not a frame completion.
  assign wrap = adv && !sync && (slot_q == LAST_SLOT);
  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux1_4.sv
// ----------------------------------------------------------------------------
// tdm_demux1_4
// Receive-side 1:4 TDM demultiplexer. Each valid beat carries one channel's
// sample in slot order 0..3. Slots 0..2 are held in capture registers; the
// slot-3 beat loads all four channel outputs at once so downstream logic
// only ever sees complete, coherent frames.
// Optional feature macro: FRAME_ERR_EN adds the err output, a one-cycle
// flag for a sync arriving mid-frame (truncated frame).
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active-high
//   din          in   TDM sample
//   din_valid    in   din carries a sample this cycle
//   sync         in   with din_valid: this sample is slot 0
//   y0..y3       out  channel outputs, updated once per completed frame
//   frame_valid  out  one-cycle pulse when y0..y3 were just loaded
//   slot         out  next slot to be filled
//   err          out  (FRAME_ERR_EN only) truncated-frame flag
// ----------------------------------------------------------------------------
module tdm_demux1_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic [1:0]       slot
`ifdef FRAME_ERR_EN
  ,
  output logic             err
`endif
);

  slot_t            slot_q;
  logic             wrap;
  logic             syncBeat;

  logic [WIDTH-1:0] capture_q [NUM_CH-1];
  logic [WIDTH-1:0] capture_d [NUM_CH-1];
  logic [WIDTH-1:0] chan_q    [NUM_CH];
  logic [WIDTH-1:0] chan_d    [NUM_CH];
  logic             frameValid_q;

  assign syncBeat = din_valid && sync;

  tdm_slot_ctr u_slotCtr (
    .clk  (clk),
    .rst  (rst),
    .adv  (din_valid),
    .sync (sync),
    .slot (slot_q),
    .wrap (wrap)
  );

  // Capture write-enable decode. A sync beat always lands in slot 0; the
  // stale contents of slots 1..2 are simply overwritten as the new frame
  // arrives, so they never need clearing. Slot-3 beats bypass the capture
  // registers and go straight to the outputs.
  always_comb begin
    capture_d = capture_q;
    if (syncBeat) begin
      capture_d[0] = din;
    end else if (din_valid) begin
      case (slot_q)
        2'd0:    capture_d[0] = din;
        2'd1:    capture_d[1] = din;
        2'd2:    capture_d[2] = din;
        default: capture_d = capture_q;
      endcase
    end
  end

  // Output load: the whole frame is transferred in one edge when the
  // last slot is accepted, so y0..y3 change together.
  always_comb begin
    chan_d = chan_q;
    if (wrap) begin
      chan_d[0] = capture_q[0];
      chan_d[1] = capture_q[1];
      chan_d[2] = capture_q[2];
      chan_d[3] = din;
    end
  end

  // Capture/output registers and the frame strobe. Reset discards the
  // partial frame and clears the visible outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH - 1; i++) begin
        capture_q[i] <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        chan_q[i] <= '0;
      end
      frameValid_q <= 1'b0;
    end else begin
      capture_q    <= capture_d;
      chan_q       <= chan_d;
      frameValid_q <= wrap;
    end
  end

`ifdef FRAME_ERR_EN
  logic err_q;

  // A sync seen while a frame is partially received means that frame was
  // truncated; flag it for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= syncBeat && (slot_q != '0);
    end
  end

  assign err = err_q;
`endif

  assign y0          = chan_q[0];
  assign y1          = chan_q[1];
  assign y2          = chan_q[2];
  assign y3          = chan_q[3];
  assign frame_valid = frameValid_q;
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux1_4.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux1_4
// Self-checking bench for tdm_demux1_4. A queue-based frame model tracks
// received beats and the frames they complete; a negedge process compares
// every output against it each cycle, and directed scenarios add literal
// expectations. Honours FRAME_ERR_EN for the err output.
// ----------------------------------------------------------------------------
module tb_tdm_demux1_4;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic             frame_valid;
  logic [1:0]       slot;
`ifdef FRAME_ERR_EN
  logic             err;
`endif

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn    = 1'b0;

  tdm_demux1_4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .slot        (slot)
`ifdef FRAME_ERR_EN
    ,
    .err         (err)
`endif
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Frame model: the beats of the frame in progress sit in a queue. A sync
  // restarts the queue; four queued beats form a frame, published on the
  // following cycle. The next slot is simply how many beats are queued.
  logic [WIDTH-1:0] pending [$];
  logic [WIDTH-1:0] expY [4] = '{default: '0};
  bit               expFv  = 1'b0;
  bit               expErr = 1'b0;

  always @(posedge clk) begin
    expFv  = 1'b0;
    expErr = 1'b0;
    if (rst) begin
      pending.delete();
      expY = '{default: '0};
    end else if (din_valid) begin
      if (sync) begin
        expErr = (pending.size() != 0);
        pending.delete();
      end
      pending.push_back(din);
      if (pending.size() == 4) begin
        for (int i = 0; i < 4; i++) expY[i] = pending[i];
        expFv = 1'b1;
        pending.delete();
      end
    end
  end

  // Single comparison point for named checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the frame model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("mon_y0", 32'(y0), 32'(expY[0]));
      checkOutput("mon_y1", 32'(y1), 32'(expY[1]));
      checkOutput("mon_y2", 32'(y2), 32'(expY[2]));
      checkOutput("mon_y3", 32'(y3), 32'(expY[3]));
      checkOutput("mon_frame_valid", 32'(frame_valid), 32'(expFv));
      checkOutput("mon_slot", 32'(slot), 32'(pending.size()));
`ifdef FRAME_ERR_EN
      checkOutput("mon_err", 32'(err), 32'(expErr));
`endif
    end
  end

  // Waits for the next falling edge, then drives one cycle of inputs.
  // Outputs seen right after this call reflect the previous cycle's beat.
  task automatic applyStimulus(input bit r, input bit v, input bit s,
                               input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst       = r;
    din_valid = v;
    sync      = s;
    din       = d;
  endtask

  task automatic beat(input bit s, input logic [WIDTH-1:0] d);
    applyStimulus(1'b0, 1'b1, s, d);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE);
  endtask

  task automatic checkFrame(input string tag, input logic [WIDTH-1:0] e0,
                            input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                            input logic [WIDTH-1:0] e3, input bit efv);
    checkOutput({tag, "_y0"}, 32'(y0), 32'(e0));
    checkOutput({tag, "_y1"}, 32'(y1), 32'(e1));
    checkOutput({tag, "_y2"}, 32'(y2), 32'(e2));
    checkOutput({tag, "_y3"}, 32'(y3), 32'(e3));
    checkOutput({tag, "_fv"}, 32'(frame_valid), 32'(efv));
  endtask

  int pulses;

  initial begin
    rst       = 1'b1;
    din_valid = 1'b1;
    sync      = 1'b1;
    din       = 8'h5A;

    // 1: reset held two cycles with valid beats present.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
    checkEn = 1'b1;
    checkFrame("t1", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("t1_slot", 32'(slot), 32'd0);
`ifdef FRAME_ERR_EN
    checkOutput("t1_err", 32'(err), 32'd0);
`endif

    // 2: back-to-back frame A0..A3.
    beat(1'b1, 8'hA0);
    checkOutput("t2_slot_after_rst", 32'(slot), 32'd0);
    beat(1'b0, 8'hA1);
    beat(1'b0, 8'hA2);
    beat(1'b0, 8'hA3);
    checkFrame("t2_pre", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    idle();
    checkFrame("t2", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
    checkOutput("t2_slot", 32'(slot), 32'd0);
    idle();
    checkOutput("t2_fv_drop", 32'(frame_valid), 32'd0);

    // 3: same frame with three idle cycles between beats.
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      beat(b == 0, 8'hA0 + 8'(b));
      for (int g = 0; g < 3; g++) begin
        idle();
        if (frame_valid) pulses++;
        if (b < 3) checkOutput("t3_slot_hold", 32'(slot), 32'(b + 1));
      end
    end
    checkOutput("t3_pulses", 32'(pulses), 32'd1);
    checkFrame("t3", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0);

    // 4: truncated frame followed by a full one.
    beat(1'b1, 8'h11);
    beat(1'b0, 8'h22);
    beat(1'b1, 8'h33);
    checkOutput("t4_slot_before_resync", 32'(slot), 32'd2);
    beat(1'b0, 8'h44);
    checkOutput("t4_no_fv", 32'(frame_valid), 32'd0);
    checkOutput("t4_slot_after_resync", 32'(slot), 32'd1);
`ifdef FRAME_ERR_EN
    checkOutput("t4_err", 32'(err), 32'd1);
`endif
    beat(1'b0, 8'h55);
`ifdef FRAME_ERR_EN
    checkOutput("t4_err_drop", 32'(err), 32'd0);
`endif
    beat(1'b0, 8'h66);
    idle();
    checkFrame("t4", 8'h33, 8'h44, 8'h55, 8'h66, 1'b1);

    // 5: reset mid-frame, then an unsynced frame from slot 0.
    beat(1'b1, 8'h01);
    beat(1'b0, 8'h02);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
    beat(1'b0, 8'h03);
    checkOutput("t5_slot_rst", 32'(slot), 32'd0);
    checkFrame("t5_rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    beat(1'b0, 8'h04);
    beat(1'b0, 8'h05);
    beat(1'b0, 8'h06);
    idle();
    checkFrame("t5", 8'h03, 8'h04, 8'h05, 8'h06, 1'b1);

    // 6: eight consecutive beats, two frames four cycles apart.
    for (int b = 0; b < 8; b++) begin
      beat(b == 0, 8'h10 + 8'(b));
      if (b == 4) checkFrame("t6_f1", 8'h10, 8'h11, 8'h12, 8'h13, 1'b1);
      if (b == 5 || b == 6 || b == 7) checkOutput("t6_gap_fv", 32'(frame_valid), 32'd0);
    end
    idle();
    checkFrame("t6_f2", 8'h14, 8'h15, 8'h16, 8'h17, 1'b1);

    // Ignored sync while idle must not disturb anything.
    idle();
    idle();
    checkFrame("t7_idle", 8'h14, 8'h15, 8'h16, 8'h17, 1'b0);
    checkOutput("t7_slot", 32'(slot), 32'd0);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
